// File: rtl/sdc_sched_pkg.sv
// Shared constants for the SD-card write scheduler and the writer it feeds.
package sdc_sched_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARB   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ABORT = 3'd5;

    localparam int unsigned BLOCK_BYTES_DEF = 512;

    // Start-of-block token the writer emits ahead of each data block.
    localparam logic [7:0] SOB_TOKEN = 8'hFE;

endpackage

// File: rtl/sdc_rr_arb2.sv
// Two-input round-robin arbiter: combinational winner, registered favour pointer.
module sdc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] winner_c
);

    logic ptr;

    always_comb begin
        winner_c = req;
        if (req == 2'b11) begin
            winner_c = ptr ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves to the requester that did not win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (update && (req != 2'b00)) begin
            ptr <= winner_c[0];
        end
    end

endmodule

// File: rtl/sdc_write_sched.sv
// Shares one SD-card write datapath between two RAM-buffer requesters.
module sdc_write_sched
    import sdc_sched_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int unsigned SIZE_W      = 8,
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [SIZE_W-1:0] blocks0,
    input  logic [7:0]        data0,
    input  logic              empty0,
    input  logic              req1,
    input  logic [SIZE_W-1:0] blocks1,
    input  logic [7:0]        data1,
    input  logic              empty1,
    output logic              grant0,
    output logic              grant1,
    output logic              rd0,
    output logic              rd1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic              wr_start,
    output logic [SIZE_W-1:0] wr_size,
    output logic [7:0]        wr_data,
    output logic              wr_empty,
    input  logic              wr_bytes,
    output logic              busy
);

    localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned BB_SHIFT = $clog2(BLOCK_BYTES);
    localparam bit          BB_POW2  = (BLOCK_BYTES == (32'd1 << BB_SHIFT));

    logic [2:0]        state, stateNext;
    logic [1:0]        grantQ, grantNext;
    logic [1:0]        doneNext, errNext;
    logic              wrStartNext;
    logic [SIZE_W-1:0] sizeNext, winBlocks;
    logic [CNT_W-1:0]  cnt, cntNext, jobBytes;
    logic [WD_W-1:0]   wd, wdNext;
    logic [1:0]        winner;
    logic              arbUpdate;

    sdc_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (reset),
        .req      ({req1, req0}),
        .update   (arbUpdate),
        .winner_c (winner)
    );

    assign winBlocks = winner[1] ? blocks1 : blocks0;
    assign jobBytes  = BB_POW2 ? (CNT_W'(winBlocks) << BB_SHIFT)
                               : (CNT_W'(winBlocks) * CNT_W'(BLOCK_BYTES));

    // Next-state and next-output logic.
    always_comb begin
        stateNext   = state;
        grantNext   = grantQ;
        doneNext    = 2'b00;
        errNext     = 2'b00;
        wrStartNext = 1'b0;
        sizeNext    = wr_size;
        cntNext     = cnt;
        wdNext      = wd;
        arbUpdate   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    stateNext = ARB;
                end
            end
            ARB: begin
                arbUpdate = 1'b1;
                if (winner == 2'b00) begin
                    stateNext = IDLE;
                end else begin
                    grantNext = winner;
                    sizeNext  = winBlocks;
                    cntNext   = jobBytes;
                    if (winBlocks == '0) begin
                        stateNext = DONE;
                        doneNext  = winner;
                    end else begin
                        stateNext   = START;
                        wrStartNext = 1'b1;
                    end
                end
            end
            START: begin
                wdNext    = '0;
                stateNext = RUN;
            end
            RUN: begin
                // A strobe always clears the watchdog, so it beats a same-cycle timeout.
                if (wr_bytes) begin
                    cntNext = cnt - CNT_W'(1);
                    wdNext  = '0;
                    if (cnt == CNT_W'(1)) begin
                        stateNext = DONE;
                        doneNext  = grantQ;
                    end
                end else begin
                    wdNext = wd + WD_W'(1);
                    if (wd == WD_W'(TIMEOUT - 1)) begin
                        stateNext = ABORT;
                        errNext   = grantQ;
                    end
                end
            end
            DONE, ABORT: begin
                stateNext = IDLE;
                grantNext = 2'b00;
            end
            default: begin
                stateNext = IDLE;
                grantNext = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grantQ   <= 2'b00;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            wr_start <= 1'b0;
            wr_size  <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            wd       <= '0;
        end else begin
            state    <= stateNext;
            grantQ   <= grantNext;
            done0    <= doneNext[0];
            done1    <= doneNext[1];
            err0     <= errNext[0];
            err1     <= errNext[1];
            wr_start <= wrStartNext;
            wr_size  <= sizeNext;
            busy     <= (stateNext != IDLE);
            cnt      <= cntNext;
            wd       <= wdNext;
        end
    end

    assign grant0 = grantQ[0];
    assign grant1 = grantQ[1];

    // Byte strobes reach the owner only while a job is actually running.
    assign rd0 = wr_bytes && grantQ[0] && (state == RUN);
    assign rd1 = wr_bytes && grantQ[1] && (state == RUN);

    assign wr_data  = grantQ[0] ? data0  : (grantQ[1] ? data1  : 8'h00);
    assign wr_empty = grantQ[0] ? empty0 : (grantQ[1] ? empty1 : 1'b1);

endmodule
